// File: rtl/dcache_responder_if.sv
// Bundles the memory-stage request/response signals and the memory-controller
// handshake of the data cache; "slave" is the cache, "master" is its environment.
interface dcache_responder_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        halt;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-line, write-through, no-write-allocate data cache.
// Define DCACHE_STATS_EN to add the hit_count / miss_count output ports.
module dcache_responder #(
    parameter int SETS = 16,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef DCACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    dcache_responder_if.slave bus
);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [SETS-1:0]  valid_reg;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      word_addr;
    logic             line_hit;
    logic             fetch_done;
    logic             write_done;
    logic             read_hit;
    logic             unused_addr;

    assign idx         = bus.dmemaddr[IDX_W+1:2];
    assign tag         = bus.dmemaddr[31:IDX_W+2];
    assign word_addr   = {bus.dmemaddr[31:2], 2'b00};
    assign unused_addr = &{1'b0, bus.dmemaddr[1:0]};

    assign line_hit   = valid_reg[idx] && (tag_mem[idx] == tag);
    assign fetch_done = (state_reg == FETCH) && !bus.dwait;
    assign write_done = (state_reg == WRITE) && !bus.dwait;
    // halt and a pending write both pre-empt a read hit in IDLE
    assign read_hit   = (state_reg == IDLE) && !bus.halt && !bus.dmemWEN &&
                        bus.dmemREN && line_hit;

    always_comb begin
        state_next   = state_reg;
        bus.dhit     = 1'b0;
        bus.dmemload = 32'd0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'd0;
        bus.dstore   = 32'd0;
        bus.flushed  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.halt) begin
                    state_next = FLUSH;
                end else if (bus.dmemWEN) begin
                    state_next = WRITE;
                end else if (bus.dmemREN) begin
                    if (line_hit) begin
                        bus.dhit     = 1'b1;
                        bus.dmemload = data_mem[idx];
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                bus.dREN  = 1'b1;
                bus.daddr = word_addr;
                if (!bus.dwait) begin
                    bus.dhit     = 1'b1;
                    bus.dmemload = bus.dload;
                    state_next   = IDLE;
                end
            end
            WRITE: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = word_addr;
                bus.dstore = bus.dmemstore;
                if (!bus.dwait) begin
                    bus.dhit   = 1'b1;
                    state_next = IDLE;
                end
            end
            FLUSH: state_next = DONE;
            DONE:  bus.flushed = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // One valid flop per line so FLUSH can clear the whole cache in a cycle.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
        always_ff @(posedge CLK) begin
            if (RST || state_reg == FLUSH) begin
                valid_reg[gi] <= 1'b0;
            end else if (fetch_done && idx == IDX_W'(gi)) begin
                valid_reg[gi] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset; a line is only trusted via valid_reg.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (fetch_done) begin
                data_mem[idx] <= bus.dload;
                tag_mem[idx]  <= tag;
            end else if (write_done && line_hit) begin
                data_mem[idx] <= bus.dmemstore;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;
    logic        miss_start;

    assign miss_start = (state_reg != FETCH) && (state_next == FETCH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_reg  <= 32'd0;
            miss_count_reg <= 32'd0;
        end else begin
            if (read_hit) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss_start) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`else
    logic unused_read_hit;
    assign unused_read_hit = read_hit;
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// Directed, table-driven bench for dcache_responder (one vector per clock cycle)
// plus hand-written reset/halt and statistics sequences.
module tb_dcache_responder;
    logic CLK;
    logic RST;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_responder_if bus ();

    dcache_responder #(.SETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
`ifdef DCACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .bus        (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren, wen, hlt, dwait;
        logic [31:0] addr, store, dload;
        logic        e_dhit, e_dren, e_dwen, e_flushed;
        logic [31:0] e_load, e_daddr, e_dstore;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic vec_t mk(input logic ren, wen, hlt, dwait,
                                input logic [31:0] addr, store, dload,
                                input logic e_dhit, e_dren, e_dwen, e_flushed,
                                input logic [31:0] e_load, e_daddr, e_dstore);
        vec_t v;
        v = '{ren, wen, hlt, dwait, addr, store, dload,
              e_dhit, e_dren, e_dwen, e_flushed, e_load, e_daddr, e_dstore};
        return v;
    endfunction

    task automatic check(input string name, input logic ok, input string detail);
        total_cnt++;
        if (ok) begin
            pass_cnt++;
            $display("ok   %s: %s", name, detail);
        end else begin
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic drive(input logic ren, wen, hlt, dwait,
                         input logic [31:0] addr, store, dload);
        bus.dmemREN   = ren;
        bus.dmemWEN   = wen;
        bus.halt      = hlt;
        bus.dwait     = dwait;
        bus.dmemaddr  = addr;
        bus.dmemstore = store;
        bus.dload     = dload;
    endtask

    function automatic string outs();
        return $sformatf("got dhit=%0b dREN=%0b dWEN=%0b flushed=%0b load=%h daddr=%h dstore=%h",
                         bus.dhit, bus.dREN, bus.dWEN, bus.flushed,
                         bus.dmemload, bus.daddr, bus.dstore);
    endfunction

    initial begin
        vec_t v;
        logic ok;
        // ren wen hlt dwait  addr  store  dload  | dhit dREN dWEN flushed  load  daddr  dstore
        vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,        32'h0,        0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(1,0,0,1, 32'h40,  32'h0,        32'h0,        0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(1,0,0,1, 32'h40,  32'h0,        32'h0,        0,1,0,0, 32'h0,        32'h40,  32'h0));
        vecs.push_back(mk(1,0,0,1, 32'h40,  32'h0,        32'h0,        0,1,0,0, 32'h0,        32'h40,  32'h0));
        vecs.push_back(mk(1,0,0,1, 32'h40,  32'h0,        32'h0,        0,1,0,0, 32'h0,        32'h40,  32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h40,  32'h0,        32'hDEADBEEF, 1,1,0,0, 32'hDEADBEEF, 32'h40,  32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h40,  32'h0,        32'h0,        1,0,0,0, 32'hDEADBEEF, 32'h0,   32'h0));
        vecs.push_back(mk(0,1,0,1, 32'h40,  32'h12345678, 32'h0,        0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(0,1,0,1, 32'h40,  32'h12345678, 32'h0,        0,0,1,0, 32'h0,        32'h40,  32'h12345678));
        vecs.push_back(mk(0,1,0,0, 32'h40,  32'h12345678, 32'h0,        1,0,1,0, 32'h0,        32'h40,  32'h12345678));
        vecs.push_back(mk(1,0,0,0, 32'h40,  32'h0,        32'h0,        1,0,0,0, 32'h12345678, 32'h0,   32'h0));
        vecs.push_back(mk(0,1,0,1, 32'h80,  32'hAAAA5555, 32'h0,        0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(0,1,0,0, 32'h80,  32'hAAAA5555, 32'h0,        1,0,1,0, 32'h0,        32'h80,  32'hAAAA5555));
        vecs.push_back(mk(1,0,0,0, 32'h40,  32'h0,        32'h0,        1,0,0,0, 32'h12345678, 32'h0,   32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h440, 32'h0,        32'h0BADF00D, 0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h440, 32'h0,        32'h0BADF00D, 1,1,0,0, 32'h0BADF00D, 32'h440, 32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h440, 32'h0,        32'h0,        1,0,0,0, 32'h0BADF00D, 32'h0,   32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h40,  32'h0,        32'h11111111, 0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h40,  32'h0,        32'h11111111, 1,1,0,0, 32'h11111111, 32'h40,  32'h0));
        vecs.push_back(mk(1,1,0,0, 32'h40,  32'h22222222, 32'h0,        0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(1,1,0,0, 32'h40,  32'h22222222, 32'h0,        1,0,1,0, 32'h0,        32'h40,  32'h22222222));
        vecs.push_back(mk(1,0,0,0, 32'h40,  32'h0,        32'h0,        1,0,0,0, 32'h22222222, 32'h0,   32'h0));
        vecs.push_back(mk(1,0,0,1, 32'h48,  32'h0,        32'h0,        0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(1,0,1,1, 32'h48,  32'h0,        32'h0,        0,1,0,0, 32'h0,        32'h48,  32'h0));
        vecs.push_back(mk(1,0,1,0, 32'h48,  32'h0,        32'h48484848, 1,1,0,0, 32'h48484848, 32'h48,  32'h0));
        vecs.push_back(mk(1,0,1,0, 32'h48,  32'h0,        32'h0,        0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h48,  32'h0,        32'h0,        0,0,0,0, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(1,0,0,0, 32'h40,  32'h0,        32'h0,        0,0,0,1, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(0,1,0,0, 32'h40,  32'h33333333, 32'h0,        0,0,0,1, 32'h0,        32'h0,   32'h0));
        vecs.push_back(mk(0,0,0,0, 32'h0,   32'h0,        32'h0,        0,0,0,1, 32'h0,        32'h0,   32'h0));

        RST = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        ok = !bus.dhit && !bus.dREN && !bus.dWEN && !bus.flushed &&
             bus.dmemload == 32'h0 && bus.daddr == 32'h0 && bus.dstore == 32'h0;
        check("reset_outputs", ok, $sformatf("%s want all zero", outs()));
`ifdef DCACHE_STATS_EN
        check("reset_counters", hit_count == 32'd0 && miss_count == 32'd0,
              $sformatf("got hits=%0d misses=%0d want 0/0", hit_count, miss_count));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.ren, v.wen, v.hlt, v.dwait, v.addr, v.store, v.dload);
            #1;
            ok = bus.dhit == v.e_dhit && bus.dREN == v.e_dren && bus.dWEN == v.e_dwen &&
                 bus.flushed == v.e_flushed &&
                 (!(v.e_dhit && v.ren && !v.wen) || bus.dmemload == v.e_load) &&
                 (!(v.e_dren || v.e_dwen) || bus.daddr == v.e_daddr) &&
                 (!v.e_dwen || bus.dstore == v.e_dstore);
            check($sformatf("vec%0d", i), ok,
                  $sformatf("%s want dhit=%0b dREN=%0b dWEN=%0b flushed=%0b load=%h daddr=%h dstore=%h",
                            outs(), v.e_dhit, v.e_dren, v.e_dwen, v.e_flushed,
                            v.e_load, v.e_daddr, v.e_dstore));
            @(negedge CLK);
        end

`ifdef DCACHE_STATS_EN
        // Reads that hit in IDLE: 5; entries into FETCH: 4; frozen since DONE.
        check("stats_after_run", hit_count == 32'd5 && miss_count == 32'd4,
              $sformatf("got hits=%0d misses=%0d want 5/4", hit_count, miss_count));
`endif

        // Only reset leaves DONE; the cache must come back empty.
        RST = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_clears_flushed", !bus.flushed && !bus.dhit,
              $sformatf("%s want flushed=0 dhit=0", outs()));
`ifdef DCACHE_STATS_EN
        check("rst_clears_counters", hit_count == 32'd0 && miss_count == 32'd0,
              $sformatf("got hits=%0d misses=%0d want 0/0", hit_count, miss_count));
`endif
        drive(1, 0, 0, 0, 32'h40, 32'h0, 32'h00000005);
        #1;
        check("post_rst_read_misses", !bus.dhit && !bus.dREN,
              $sformatf("%s want dhit=0 dREN=0", outs()));
        @(negedge CLK);
        #1;
        check("post_rst_fill", bus.dhit && bus.dREN && bus.daddr == 32'h40 &&
                               bus.dmemload == 32'h00000005,
              $sformatf("%s want dhit=1 dREN=1 daddr=00000040 load=00000005", outs()));
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        @(negedge CLK);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
